// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - rv32i fetch stage: PC, credit-limited imem requests, {pc, instr} FIFO to decode
// Redirect flushes the FIFO and turns in-flight responses into discards.
module instruction_fetch #(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [31:0]     imem_resp_data,
   input  logic            redirect,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [31:0]     instruction,
   output logic [XLEN-1:0] instr_pc,
   output logic [XLEN-1:0] instr_pc_plus4
);
   localparam int          AW    = $clog2(DEPTH);
   localparam int          CW    = $clog2(DEPTH + 1);
   localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);
   localparam logic [31:0] NOP   = 32'h00000013;

   logic [XLEN-1:0] fetch_pc;
   logic [XLEN-1:0] resp_pc;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   discard;
   logic [CW-1:0]   count;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   wr_ptr;
   logic [XLEN-1:0] pc_mem   [DEPTH];
   logic [31:0]     data_mem [DEPTH];

   logic            accept;
   logic            push;
   logic            pop;
   logic            resp_drop;
   logic [CW:0]     in_use;
   logic [XLEN-1:0] target;
   logic [CW-1:0]   outstanding_after_resp;

   // Requests in flight plus buffered entries never exceed DEPTH, so every kept response has a slot.
   assign in_use         = {1'b0, outstanding} + {1'b0, count};
   assign imem_req_valid = rst_n && !redirect && (in_use < LIMIT);
   assign imem_req_addr  = fetch_pc;

   assign accept    = imem_req_valid && imem_req_ready;
   assign push      = imem_resp_valid && (discard == '0) && !redirect;
   assign resp_drop = imem_resp_valid && (discard != '0);
   assign pop       = instr_valid && instr_ready && !redirect;

   assign target                 = redirect_pc & ~XLEN'(3);
   assign outstanding_after_resp = outstanding - CW'(imem_resp_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         discard     <= '0;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else if (redirect) begin
         // Whatever is still in flight after this cycle's response belongs to the old stream.
         fetch_pc    <= target;
         resp_pc     <= target;
         outstanding <= outstanding_after_resp;
         discard     <= outstanding_after_resp;
         count       <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (accept)
            fetch_pc <= fetch_pc + XLEN'(4);
         if (push) begin
            resp_pc <= resp_pc + XLEN'(4);
            wr_ptr  <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (resp_drop)
            discard <= discard - CW'(1);
         outstanding <= outstanding + CW'(accept) - CW'(imem_resp_valid);
         count       <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= resp_pc;
         data_mem[wr_ptr] <= imem_resp_data;
      end
   end

   assign instr_valid    = (count != '0);
   assign instruction    = instr_valid ? data_mem[rd_ptr] : NOP;
   assign instr_pc       = instr_valid ? pc_mem[rd_ptr] : '0;
   assign instr_pc_plus4 = instr_pc + XLEN'(4);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed bench for instruction_fetch with a variable-latency memory model
// The memory returns the request address as the instruction word.
module tb_instruction_fetch;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        instr_valid;
   logic        instr_ready = 1'b1;
   logic [31:0] instruction;
   logic [31:0] instr_pc;
   logic [31:0] instr_pc_plus4;

   int n_assert = 0;
   int n_fail   = 0;

   int          lat = 1;
   int          cyc = 0;
   int          n_acc = 0;
   int          max_q = 0;
   logic [31:0] q_addr[$];
   int          q_due[$];

   instruction_fetch #(.XLEN(32), .RESET_PC(32'h0), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .instr_pc_plus4 (instr_pc_plus4)
   );

   always #5 clk = ~clk;

   // Memory model: capture accepted requests, retire the presented response.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_addr.delete();
         q_due.delete();
         n_acc = 0;
         max_q = 0;
      end else begin
         if (imem_resp_valid && q_addr.size() > 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
         end
         if (imem_req_valid && imem_req_ready) begin
            q_addr.push_back(imem_req_addr);
            q_due.push_back(cyc + lat);
            n_acc++;
         end
         if (q_addr.size() > max_q)
            max_q = q_addr.size();
         cyc++;
      end
   end

   always @(negedge clk) begin
      if (q_addr.size() > 0 && q_due[0] <= cyc) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = q_addr[0];
      end else begin
         imem_resp_valid = 1'b0;
         imem_resp_data  = 32'hdeadbeef;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Called at a negedge with instr_ready = 1; expects n consecutive PCs from start.
   task automatic run_stream(input logic [31:0] start, input int n, input int budget);
      logic [31:0] exp_pc;
      int          got;
      exp_pc = start;
      got    = 0;
      for (int c = 0; c < budget && got < n; c++) begin
         if (instr_valid && instr_ready) begin
            check("stream_pc", instr_pc, exp_pc);
            check("stream_instr", instruction, exp_pc);
            check("stream_pc_plus4", instr_pc_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            got++;
         end
         @(negedge clk);
      end
      check("stream_count", 32'(got), 32'(n));
   endtask

   initial begin
      #1;
      check("rst_instr_valid", 32'(instr_valid), 32'd0);
      check("rst_req_valid", 32'(imem_req_valid), 32'd0);
      check("rst_instruction", instruction, 32'h00000013);
      check("rst_instr_pc", instr_pc, 32'h0);
      check("rst_pc_plus4", instr_pc_plus4, 32'h4);

      // Streaming with 1-cycle memory and decode always ready.
      lat = 1; instr_ready = 1'b1;
      do_reset();
      #1;
      check("first_req_valid", 32'(imem_req_valid), 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0);
      @(negedge clk);
      check("e1_instr_valid", 32'(instr_valid), 32'd0);
      @(negedge clk);
      check("e2_instr_valid", 32'(instr_valid), 32'd1);
      run_stream(32'h0, 10, 60);

      // Decode stall: only DEPTH requests accepted, head holds PC 0.
      instr_ready = 1'b0;
      do_reset();
      repeat (8) @(negedge clk);
      check("stall_accepts", 32'(n_acc), 32'd2);
      check("stall_req_valid", 32'(imem_req_valid), 32'd0);
      check("stall_instr_valid", 32'(instr_valid), 32'd1);
      check("stall_head_pc", instr_pc, 32'h0);
      check("stall_head_instr", instruction, 32'h0);
      instr_ready = 1'b1;
      run_stream(32'h0, 6, 60);

      // Memory latency 3: in-flight never above 2.
      lat = 3;
      do_reset();
      run_stream(32'h0, 8, 120);
      check("lat3_max_outstanding", 32'(max_q), 32'd2);

      // Redirect with two requests in flight.
      do_reset();
      @(negedge clk);
      @(negedge clk);
      check("rd1_inflight", 32'(n_acc), 32'd2);
      redirect = 1'b1; redirect_pc = 32'h100;
      #1;
      check("rd1_req_blocked", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      check("rd1_credit_held", 32'(imem_req_valid), 32'd0);
      check("rd1_fifo_empty", 32'(instr_valid), 32'd0);
      run_stream(32'h100, 4, 60);

      // Redirect together with a response and a pop; target is misaligned.
      lat = 1;
      do_reset();
      @(negedge clk);
      @(negedge clk);
      check("rd2_head_valid", 32'(instr_valid), 32'd1);
      check("rd2_head_pc", instr_pc, 32'h0);
      redirect = 1'b1; redirect_pc = 32'h203;
      #1;
      check("rd2_req_blocked", 32'(imem_req_valid), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      check("rd2_fifo_empty", 32'(instr_valid), 32'd0);
      check("rd2_empty_instr", instruction, 32'h00000013);
      check("rd2_req_valid", 32'(imem_req_valid), 32'd1);
      check("rd2_req_addr", imem_req_addr, 32'h200);
      @(negedge clk);
      run_stream(32'h200, 4, 40);

      // PC wrap through the top of the address space.
      do_reset();
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
      @(negedge clk);
      redirect = 1'b0;
      #1;
      check("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      run_stream(32'hFFFF_FFFC, 3, 40);

      // Asynchronous reset mid-stream.
      do_reset();
      @(negedge clk);
      @(negedge clk);
      check("ar_pre_valid", 32'(instr_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_instr_valid", 32'(instr_valid), 32'd0);
      check("ar_req_valid", 32'(imem_req_valid), 32'd0);
      check("ar_instruction", instruction, 32'h00000013);
      check("ar_instr_pc", instr_pc, 32'h0);
      check("ar_pc_plus4", instr_pc_plus4, 32'h4);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ar_restart_valid", 32'(imem_req_valid), 32'd1);
      check("ar_restart_addr", imem_req_addr, 32'h0);
      @(negedge clk);
      run_stream(32'h0, 4, 40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
